// File: rtl/logic_circuit.sv
// AOI22 / OAI22 complex-gate leaf cell with optionally registered outputs.
// OUT_REG=1 gives one cycle of latency; OUT_REG=0 is a purely combinational path.
module logic_circuit #(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic F1,
    output logic F2
);

    logic f1_n;
    logic f2_n;

    always_comb begin
        f1_n = ~((a & b) | (c & d));
        f2_n = ~((a | b) & (c | d));
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic f1_d, f1_q;
            logic f2_d, f2_q;

            always_comb begin
                f1_d = f1_n;
                f2_d = f2_n;
            end

            // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    f1_q <= 1'b0;
                    f2_q <= 1'b0;
                end else begin
                    f1_q <= f1_d;
                    f2_q <= f2_d;
                end
            end

            assign F1 = f1_q;
            assign F2 = f2_q;
        end else begin : g_comb
            // clk and rst have no function on the combinational path.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign F1 = f1_n;
            assign F2 = f2_n;
        end
    endgenerate

endmodule

// File: tb/tb_logic_circuit.sv
// Bench for logic_circuit: registered and combinational instances driven from shared inputs.
// Registered results are checked through an expected-value queue drained by a monitor.
module tb_logic_circuit;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst;
    logic a, b, c, d;
    logic f1_reg, f2_reg;
    logic f1_comb, f2_comb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] abcd;
        logic [1:0] f;
    } exp_t;

    exp_t exp_q[$];

    // Hand-derived truth tables, bit index = {a,b,c,d}
    logic [15:0] f1_tbl;
    logic [15:0] f2_tbl;

    logic_circuit #(.OUT_REG(1)) dut_reg (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .F1(f1_reg), .F2(f2_reg)
    );

    logic_circuit #(.OUT_REG(0)) dut_comb (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .F1(f1_comb), .F2(f2_comb)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got F1F2=%b expected F1F2=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the registered output presents a new result one edge after each issued vector
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("reg abcd=%b", e.abcd), {f1_reg, f2_reg}, e.f);
            end
        end
    end

    initial begin
        f1_tbl = 16'h0777;
        f2_tbl = 16'h111F;
        rst = 1'b1;
        {a, b, c, d} = 4'b0000;

        // Reset holds outputs at 0 with no clock running
        #1;
        check("reset 0000", {f1_reg, f2_reg}, 2'b00);
        {a, b, c, d} = 4'b1111;
        #1;
        check("reset 1111", {f1_reg, f2_reg}, 2'b00);

        // Combinational instance ignores rst, no clock present
        {a, b, c, d} = 4'b0101;
        #1;
        check("comb 0101 rst=1", {f1_comb, f2_comb}, 2'b10);
        rst = 1'b0;
        #1;
        check("comb 0101 rst=0", {f1_comb, f2_comb}, 2'b10);
        rst = 1'b1;
        #1;
        check("comb 0101 rst=1 again", {f1_comb, f2_comb}, 2'b10);
        check("reg still reset", {f1_reg, f2_reg}, 2'b00);

        // Release reset, then one edge loads 0000 -> 1/1
        {a, b, c, d} = 4'b0000;
        #1;
        rst = 1'b0;
        #1;
        check("after release no edge", {f1_reg, f2_reg}, 2'b00);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("first edge 0000", {f1_reg, f2_reg}, 2'b11);

        // Exhaustive sweep through the scoreboard
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            logic [3:0] v;
            @(negedge clk);
            v = 4'(i);
            {a, b, c, d} = v;
            e.abcd = v;
            e.f = {f1_tbl[i], f2_tbl[i]};
            exp_q.push_back(e);
            #1;
            check($sformatf("comb abcd=%b", v), {f1_comb, f2_comb}, e.f);
        end
        @(posedge clk);
        #2;
        check("scoreboard drained", {1'b0, exp_q.size() != 0}, 2'b00);

        // Latency: mid-cycle change has no effect until the next rising edge
        @(negedge clk);
        {a, b, c, d} = 4'b0000;
        @(posedge clk);
        #2;
        check("latency 0000 loaded", {f1_reg, f2_reg}, 2'b11);
        {a, b, c, d} = 4'b1010;
        #1;
        check("latency mid-cycle hold", {f1_reg, f2_reg}, 2'b11);
        @(posedge clk);
        #1;
        check("latency 1010 loaded", {f1_reg, f2_reg}, 2'b10);

        // Asynchronous mid-operation reset
        #1;
        rst = 1'b1;
        #1;
        check("async reset clears", {f1_reg, f2_reg}, 2'b00);
        @(posedge clk);
        #1;
        check("reset held over edge", {f1_reg, f2_reg}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("recover 1010", {f1_reg, f2_reg}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
